// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding,
// default operand width and the bit-counter width helper.
package bsa_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter only ever needs to reach WIDTH-1.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_cell_nand.sv
// One-bit full adder built from nine two-input NAND gates; the only
// arithmetic element the serial sequencer time-shares.
module fa_cell_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic n1, n2, n3, n4, n5, n6, n7;

  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign n4 = ~(n2 & n3);   // a ^ b
  assign n5 = ~(n4 & cin);
  assign n6 = ~(n4 & n5);
  assign n7 = ~(cin & n5);
  assign s  = ~(n6 & n7);
  assign co = ~(n5 & n1);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one NAND full-adder cell, one bit per clock,
// LSB first, with start/done/ack handshake. SERIAL_SUB_EN adds a sub port.
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q, b_cap;
  logic [CW-1:0]    cnt;
  logic             carry_q, cout_q, busy_q, done_q, cin_cap;
  logic             cell_s, cell_co;

`ifdef SERIAL_SUB_EN
  // a - b == a + ~b + 1; the caller's carry_in is overridden.
  assign b_cap   = sub ? ~b : b;
  assign cin_cap = sub | carry_in;
`else
  assign b_cap   = b;
  assign cin_cap = carry_in;
`endif

  fa_cell_nand u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .cin(carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (ack)         state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Status flags follow the next state so they stay pure flop outputs.
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b_cap;
            carry_q <= cin_cap;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum_q   <= {cell_s, sum_q[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= cell_co;
          // Counter parks at LAST rather than wrapping on the final bit.
          if (cnt == LAST) cout_q <= cell_co;
          else             cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl with a transaction-level model
// checked every cycle plus hand-computed literal expectations.
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, ack, carry_in;
  logic [W-1:0] a, b;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy, done, carry_out;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
`ifdef SERIAL_SUB_EN
    .sub      (sub),
`endif
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a result of a+b+cin appears W edges after the accepting edge.
  logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic [W:0]   m_pend = '0;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_cout = 1'b0; m_sum = '0; m_left = 0;
    end else if (!m_busy) begin
      if (start) begin
`ifdef SERIAL_SUB_EN
        if (sub) m_pend = {(a >= b), W'(a - b)};
        else     m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
`else
        m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
`endif
        m_busy = 1'b1;
        m_left = W;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_sum  = m_pend[W-1:0];
        m_cout = m_pend[W];
      end
    end else if (ack) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("carry_out", carry_out, m_cout);
      if (!m_busy || m_done) chk("sum", sum, m_sum);
    end
  end

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts);
    @(posedge clk); #2;
    a = ta; b = tb_v; carry_in = tc; start = 1'b1;
`ifdef SERIAL_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: sub request ignored in add-only build");
`endif
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Returns the number of edges after the accepting edge until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 4 * W) begin
      @(posedge clk); #2;
      n++;
    end
    chk("done_within_bound", done, 1'b1);
  endtask

  task automatic ack_op();
    ack = 1'b1;
    @(posedge clk); #2;
    ack = 1'b0;
    chk("ack_done_low", done, 1'b0);
    chk("ack_busy_low", busy, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[4] = '{
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0}
  };

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ack = 1'b0; carry_in = 1'b0; a = '0; b = '0;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", carry_out, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic add with latency check.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    chk("busy_after_start", busy, 1'b1);
    wait_done(n);
    chk("latency", n, W);
    chk("sum_5a_3c", sum, 8'h96);
    chk("cout_5a_3c", carry_out, 1'b0);
    ack_op();

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      wait_done(n);
      chk("vec_sum", sum, vecs[i].s);
      chk("vec_cout", carry_out, vecs[i].co);
      ack_op();
    end

    // DONE holds while ack stays low.
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(n);
    repeat (5) begin
      @(posedge clk); #2;
      chk("hold_done", done, 1'b1);
      chk("hold_sum", sum, 8'h46);
      chk("hold_cout", carry_out, 1'b0);
    end
    ack_op();

    // Start mid-RUN is ignored; start+ack in DONE only returns to IDLE.
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #2; end
    a = 8'hF0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; a = '0;
    wait_done(n);
    chk("midrun_sum", sum, 8'h02);
    chk("midrun_cout", carry_out, 1'b0);
    start = 1'b1; ack = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; ack = 1'b0;
    chk("startack_done", done, 1'b0);
    chk("startack_busy", busy, 1'b0);
    repeat (2) begin
      @(posedge clk); #2;
      chk("no_new_op", busy, 1'b0);
    end
    chk("idle_keeps_sum", sum, 8'h02);

    // Reset in the middle of RUN clears everything at once.
    start_op(8'hA5, 8'h5B, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #2; end
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_cout", carry_out, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    start_op(8'h11, 8'h22, 1'b0, 1'b0);
    wait_done(n);
    chk("post_rst_sum", sum, 8'h33);
    chk("post_rst_cout", carry_out, 1'b0);
    ack_op();

`ifdef SERIAL_SUB_EN
    start_op(8'h10, 8'h20, 1'b1, 1'b1);
    wait_done(n);
    chk("sub_borrow_sum", sum, 8'hF0);
    chk("sub_borrow_cout", carry_out, 1'b0);
    ack_op();
    start_op(8'h20, 8'h10, 1'b0, 1'b1);
    wait_done(n);
    chk("sub_sum", sum, 8'h10);
    chk("sub_cout", carry_out, 1'b1);
    ack_op();
`endif

    @(posedge clk); #2;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder_ctrl.md
# bit_serial_adder_ctrl

Sequencer that time-shares a single one-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/done/ack handshake, so a narrow gate-level adder can serve as a multi-bit arithmetic unit. It sits between a requester that supplies operands and the full-adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand and result width in bits; must be at least 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- carry_in  input  1  initial carry; captured when start is accepted.
- ack  input  1  requester has consumed the result; sampled only in DONE.
- busy  output  1  high in RUN and DONE.
- done  output  1  high in DONE only; result valid.
- sum  output  WIDTH  result register.
- carry_out  output  1  final carry.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, capture a, b and carry_in into shift registers and the carry flop, clear the bit counter, and go to RUN. Otherwise hold.
- RUN, one bit per cycle:
  - Feed the cell a_sh[0], b_sh[0] and carry_q.
  - Shift the cell sum into sum[WIDTH-1], shifting sum right by one.
  - Shift a_sh and b_sh right by one.
  - Load carry_q with the cell carry.
  - Increment the counter.
- RUN exit: when the counter equals WIDTH-1 on a processing edge, that edge handles the last bit, loads carry_out from the cell carry, and moves to DONE.
- DONE: hold sum and carry_out stable. On ack=1, go to IDLE. sum and carry_out keep their values in IDLE until the next accepted start.
- Arithmetic: the result is (a + b + carry_in) mod 2^WIDTH. carry_out is bit WIDTH of the full sum.
- start while in RUN or DONE is ignored; it is not queued.
- ack outside DONE is ignored.
- start and ack both high in DONE: ack is honoured and start is ignored. A new start must be presented in IDLE.
- Counter width is $clog2(WIDTH). It never wraps past WIDTH-1 within an operation.

## Timing
- Reset (asynchronous, immediate): state=IDLE; busy=0, done=0, sum=0, carry_out=0; shift registers, carry_q and counter are all 0.
- Reset asserted mid-RUN or in DONE aborts the operation with no partial result retained.
- Latency: start is sampled at edge E0. RUN covers edges E0+1 through E0+WIDTH. done=1 from just after edge E0+WIDTH.
- busy rises after E0 and falls after the edge at which ack is sampled high in DONE.
- Throughput: at most one operation per WIDTH+2 cycles (start, WIDTH bits, ack).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_EN, when defined:
  - Adds input port sub (1 bit), captured with the operands.
  - If sub=1, b is captured bitwise inverted and carry_in is ignored and forced to 1, so the result is a - b mod 2^WIDTH.
  - In that case carry_out=1 means no borrow (a >= b unsigned).
- SERIAL_SUB_EN, when undefined: no sub port, addition only, behaviour exactly as above.

## Structure
- Shared package bsa_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH;
  - a counter-width helper.
- Sub-module fa_cell_nand: the one-bit full adder built from nine two-input NAND gates (a, b, cin -> s, co). It is instantiated once in bit_serial_adder_ctrl.
- The FSM, shift registers, counter and carry flop stay in the top module.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, carry_in=0, pulse start -> done rises exactly 8 cycles after the start edge; sum=0x96, carry_out=0; busy is high throughout.
- a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1. Then a=0xFF, b=0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
- Hold ack=0 for 5 cycles in DONE -> done, sum and carry_out stay stable. ack=1 -> done=0 and busy=0 after the next edge.
- Start a=0x01, b=0x01; pulse start again with a=0xF0 mid-RUN -> the second start is ignored and the result is 0x02. Assert start and ack together in DONE -> returns to IDLE and no new operation begins.
- Assert rst at cycle 3 of RUN -> all outputs are 0 immediately. A new start with 0x11+0x22 afterwards -> 0x33, carry_out=0.
- With SERIAL_SUB_EN: sub=1, a=0x10, b=0x20 -> sum=0xF0, carry_out=0. sub=1, a=0x20, b=0x10 -> sum=0x10, carry_out=1.
